// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage: decoded-instruction fields,
// machine CSR addresses and the retire/flush state encoding.
package writeback_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [11:0]     csr_addr;
    logic            is_csr;
    logic            writes_rd;
    logic [4:0]      rd;
  } instr_t;

  function automatic logic csr_writable(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) || (addr == CSR_MSCRATCH) ||
           (addr == CSR_MEPC) || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/writeback_if.sv
// Execute-to-writeback result interface; execute drives the master side.
interface writeback_if;
  import writeback_pkg::*;

  logic            in_valid;
  instr_t          in_instr;
  logic [XLEN-1:0] in_rd;
  logic [XLEN-1:0] in_csrd;
  logic            in_is_jump;
  logic [XLEN-1:0] in_jump_dest;
  logic            in_ready;

  modport master (
    output in_valid, in_instr, in_rd, in_csrd, in_is_jump, in_jump_dest,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_instr, in_rd, in_csrd, in_is_jump, in_jump_dest,
    output in_ready
  );

endinterface

// File: rtl/writeback_regfile.sv
// Integer register file: two async read ports with write-first bypass, one sync
// write port, x0 hardwired to zero.
module writeback_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr_a,
  output logic [XLEN-1:0] o_rdata_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && i_waddr != '0) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = r_regs[i_raddr_a];
    if (i_raddr_a == '0) o_rdata_a = '0;
    else if (i_we && i_waddr == i_raddr_a) o_rdata_a = i_wdata;
  end

  always_comb begin
    o_rdata_b = r_regs[i_raddr_b];
    if (i_raddr_b == '0) o_rdata_b = '0;
    else if (i_we && i_waddr == i_raddr_b) o_rdata_b = i_wdata;
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: retires execute results into the GPR and CSR files,
// issues fetch redirects for taken jumps and discards the wrong-path results behind them.
module writeback
  import writeback_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  writeback_if.slave      wb,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            retired
);

  localparam int CW = (FLUSH_DEPTH < 2) ? 1 : $clog2(FLUSH_DEPTH + 1);

  wb_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_redirect_valid, r_retired;
  logic [XLEN-1:0] r_redirect_pc;
  logic [63:0]     r_cycle, r_instret;
  logic [XLEN-1:0] r_mstatus, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic            w_retire, w_gpr_we, w_csr_we, w_jump;
  logic [XLEN-1:0] w_unused_pc;

  assign wb.in_ready   = 1'b1;
  assign w_retire      = wb.in_valid && (r_state == RUN);
  assign w_gpr_we      = w_retire && wb.in_instr.writes_rd;
  assign w_csr_we      = w_retire && wb.in_instr.is_csr;
  assign w_jump        = w_retire && wb.in_is_jump;
  assign w_unused_pc   = wb.in_instr.pc;

  writeback_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_regfile (
    .clk       (clk),
    .rstn      (rstn),
    .i_we      (w_gpr_we),
    .i_waddr   (wb.in_instr.rd),
    .i_wdata   (wb.in_rd),
    .i_raddr_a (rs1_addr),
    .o_rdata_a (rs1_data),
    .i_raddr_b (rs2_addr),
    .o_rdata_b (rs2_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Idle cycles in FLUSH leave the count alone; only real wrong-path results consume it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_jump && FLUSH_DEPTH > 0) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = CW'(FLUSH_DEPTH);
        end
      end
      FLUSH: begin
        if (wb.in_valid) begin
          if (r_cnt <= CW'(1)) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_retired        <= 1'b0;
      r_cycle          <= '0;
      r_instret        <= '0;
    end else begin
      r_redirect_valid <= w_jump;
      if (w_jump) r_redirect_pc <= wb.in_jump_dest;
      r_retired        <= w_retire;
      r_cycle          <= r_cycle + 64'd1;
      if (w_retire) r_instret <= r_instret + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mstatus  <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else if (w_csr_we) begin
      case (wb.in_instr.csr_addr)
        CSR_MSTATUS:  r_mstatus  <= wb.in_csrd;
        CSR_MTVEC:    r_mtvec    <= wb.in_csrd;
        CSR_MSCRATCH: r_mscratch <= wb.in_csrd;
        CSR_MEPC:     r_mepc     <= wb.in_csrd;
        CSR_MCAUSE:   r_mcause   <= wb.in_csrd;
        default: ;
      endcase
    end
  end

  // Counters deliberately skip the bypass and always return the registered value.
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:  csr_rdata = r_mstatus;
      CSR_MTVEC:    csr_rdata = r_mtvec;
      CSR_MSCRATCH: csr_rdata = r_mscratch;
      CSR_MEPC:     csr_rdata = r_mepc;
      CSR_MCAUSE:   csr_rdata = r_mcause;
      CSR_CYCLE:    csr_rdata = r_cycle[31:0];
      CSR_CYCLEH:   csr_rdata = r_cycle[63:32];
      CSR_INSTRET:  csr_rdata = r_instret[31:0];
      CSR_INSTRETH: csr_rdata = r_instret[63:32];
      default:      csr_rdata = '0;
    endcase
    if (w_csr_we && wb.in_instr.csr_addr == csr_raddr && csr_writable(csr_raddr))
      csr_rdata = wb.in_csrd;
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign retired        = r_retired;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: GPR/CSR retirement, bypass, jump redirect, flush and reset.
module tb_writeback;
  import writeback_pkg::*;

  logic            clk = 1'b0;
  logic            rstn;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            retired;
  int              n_checks = 0;
  int              n_errors = 0;

  writeback_if wb_if ();

  writeback #(.FLUSH_DEPTH(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .wb             (wb_if),
    .rs1_addr       (rs1_addr),
    .rs1_data       (rs1_data),
    .rs2_addr       (rs2_addr),
    .rs2_data       (rs2_data),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_if.in_valid     = 1'b0;
    wb_if.in_instr     = '0;
    wb_if.in_rd        = '0;
    wb_if.in_csrd      = '0;
    wb_if.in_is_jump   = 1'b0;
    wb_if.in_jump_dest = '0;
  endtask

  task automatic send(input logic [4:0] rd, input logic wr, input logic [31:0] val,
                      input logic jmp, input logic [31:0] dest);
    instr_t ins;
    ins           = '0;
    ins.rd        = rd;
    ins.writes_rd = wr;
    ins.pc        = 32'h10;
    wb_if.in_valid     = 1'b1;
    wb_if.in_instr     = ins;
    wb_if.in_rd        = val;
    wb_if.in_csrd      = '0;
    wb_if.in_is_jump   = jmp;
    wb_if.in_jump_dest = dest;
  endtask

  task automatic send_csr(input logic [11:0] addr, input logic [31:0] val);
    instr_t ins;
    ins          = '0;
    ins.is_csr   = 1'b1;
    ins.csr_addr = addr;
    wb_if.in_valid     = 1'b1;
    wb_if.in_instr     = ins;
    wb_if.in_rd        = '0;
    wb_if.in_csrd      = val;
    wb_if.in_is_jump   = 1'b0;
    wb_if.in_jump_dest = '0;
  endtask

  initial begin
    rstn = 1'b0;
    rs1_addr = 5'd5; rs2_addr = 5'd0; csr_raddr = 12'hC02;
    idle();
    tick(); tick();
    check("reset_x5", {32'h0, rs1_data}, 64'h0);
    check("reset_redir_v", {63'h0, redirect_valid}, 64'h0);
    check("reset_redir_pc", {32'h0, redirect_pc}, 64'h0);
    check("reset_retired", {63'h0, retired}, 64'h0);
    check("reset_instret", {32'h0, csr_rdata}, 64'h0);

    rstn = 1'b1;
    tick(); tick(); tick();
    csr_raddr = 12'hC00; #1;
    check("cycle_after_3", {32'h0, csr_rdata}, 64'h3);

    // T1 write/read with bypass
    send(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
    check("t1_bypass", {32'h0, rs1_data}, 64'hDEADBEEF);
    check("t1_other", {32'h0, rs2_data}, 64'h0);
    tick(); idle(); #1;
    check("t1_retired", {63'h0, retired}, 64'h1);
    check("t1_x5", {32'h0, rs1_data}, 64'hDEADBEEF);
    tick();
    check("t1_retired_low", {63'h0, retired}, 64'h0);

    // T2 x0 stays zero, still retires
    send(5'd0, 1'b1, 32'h7, 1'b0, 32'h0);
    rs1_addr = 5'd0; #1;
    check("t2_x0_bypass", {32'h0, rs1_data}, 64'h0);
    tick(); idle(); csr_raddr = 12'hC02; #1;
    check("t2_retired", {63'h0, retired}, 64'h1);
    check("t2_x0", {32'h0, rs1_data}, 64'h0);
    check("t2_instret", {32'h0, csr_rdata}, 64'h2);

    // T3 jump, two discards, third retires
    send(5'd1, 1'b1, 32'h11, 1'b1, 32'h40);
    tick();
    send(5'd2, 1'b1, 32'h22, 1'b0, 32'h0);
    rs1_addr = 5'd2; rs2_addr = 5'd1; #1;
    check("t3_redir_v", {63'h0, redirect_valid}, 64'h1);
    check("t3_redir_pc", {32'h0, redirect_pc}, 64'h40);
    check("t3_jump_retired", {63'h0, retired}, 64'h1);
    check("t3_x1", {32'h0, rs2_data}, 64'h11);
    check("t3_no_bypass_flush", {32'h0, rs1_data}, 64'h0);
    tick();
    send(5'd3, 1'b1, 32'h33, 1'b0, 32'h0); #1;
    check("t3_redir_pulse", {63'h0, redirect_valid}, 64'h0);
    check("t3_discard_ret", {63'h0, retired}, 64'h0);
    tick();
    send(5'd4, 1'b1, 32'h44, 1'b0, 32'h0);
    rs1_addr = 5'd4; #1;
    check("t3_discard2_ret", {63'h0, retired}, 64'h0);
    check("t3_x4_bypass", {32'h0, rs1_data}, 64'h44);
    tick(); idle(); rs1_addr = 5'd2; rs2_addr = 5'd3; #1;
    check("t3_third_retired", {63'h0, retired}, 64'h1);
    check("t3_x2", {32'h0, rs1_data}, 64'h0);
    check("t3_x3", {32'h0, rs2_data}, 64'h0);

    // T4 flush with idle gap, jump during flush ignored
    send(5'd0, 1'b0, 32'h0, 1'b1, 32'h80);
    tick(); idle(); #1;
    check("t4_redir_v", {63'h0, redirect_valid}, 64'h1);
    check("t4_redir_pc", {32'h0, redirect_pc}, 64'h80);
    tick(); tick(); tick();
    check("t4_gap_redir", {63'h0, redirect_valid}, 64'h0);
    send(5'd6, 1'b1, 32'h66, 1'b1, 32'hC0);
    tick();
    send(5'd7, 1'b1, 32'h77, 1'b0, 32'h0); #1;
    check("t4_flush_jump_noredir", {63'h0, redirect_valid}, 64'h0);
    check("t4_discard_ret", {63'h0, retired}, 64'h0);
    tick();
    send(5'd8, 1'b1, 32'h88, 1'b0, 32'h0);
    tick(); idle(); rs1_addr = 5'd6; rs2_addr = 5'd7; #1;
    check("t4_redir_still_low", {63'h0, redirect_valid}, 64'h0);
    check("t4_retired", {63'h0, retired}, 64'h1);
    check("t4_x6", {32'h0, rs1_data}, 64'h0);
    check("t4_x7", {32'h0, rs2_data}, 64'h0);
    rs1_addr = 5'd8; #1;
    check("t4_x8", {32'h0, rs1_data}, 64'h88);

    // T5 CSR file
    send_csr(12'h340, 32'h1234);
    csr_raddr = 12'h340; #1;
    check("t5_mscratch_bypass", {32'h0, csr_rdata}, 64'h1234);
    tick(); idle(); #1;
    check("t5_mscratch", {32'h0, csr_rdata}, 64'h1234);
    send_csr(12'hC80, 32'hFFFFFFFF);
    csr_raddr = 12'hC80; #1;
    check("t5_ro_no_bypass", {32'h0, csr_rdata}, 64'h0);
    tick(); idle(); #1;
    check("t5_ro_ignored", {32'h0, csr_rdata}, 64'h0);
    send_csr(12'h7FF, 32'h5555);
    tick(); idle(); csr_raddr = 12'h7FF; #1;
    check("t5_unmapped", {32'h0, csr_rdata}, 64'h0);
    csr_raddr = 12'hC02; #1;
    check("t5_instret", {32'h0, csr_rdata}, 64'h9);
    csr_raddr = 12'hC82; #1;
    check("t5_instreth", {32'h0, csr_rdata}, 64'h0);

    // T6 reset while in FLUSH
    send(5'd9, 1'b1, 32'h99, 1'b1, 32'h100);
    tick(); idle(); #1;
    check("t6_redir_v", {63'h0, redirect_valid}, 64'h1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rs1_addr = 5'd5; rs2_addr = 5'd9; csr_raddr = 12'h340; #1;
    check("t6_x5", {32'h0, rs1_data}, 64'h0);
    check("t6_x9", {32'h0, rs2_data}, 64'h0);
    check("t6_mscratch", {32'h0, csr_rdata}, 64'h0);
    check("t6_redir_v_low", {63'h0, redirect_valid}, 64'h0);
    csr_raddr = 12'hC02; #1;
    check("t6_instret", {32'h0, csr_rdata}, 64'h0);
    send(5'd10, 1'b1, 32'hAA, 1'b0, 32'h0);
    tick(); idle(); rs1_addr = 5'd10; #1;
    check("t6_first_retired", {63'h0, retired}, 64'h1);
    check("t6_x10", {32'h0, rs1_data}, 64'hAA);
    check("t6_instret_1", {32'h0, csr_rdata}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
